// File: rtl/pipelined_csel_adder_pkg.sv
// Shared defaults and parameter helpers for the pipelined carry-select adder.
package adder_pkg;

  localparam int W_DEFAULT      = 128;
  localparam int BLK_DEFAULT    = 4;
  localparam int STAGES_DEFAULT = 4;

  // Number of carry-select blocks each pipeline stage resolves.
  function automatic int blocks_per_stage(int w, int blk, int stages);
    return (w / blk) / stages;
  endfunction

  // Width must split evenly into blocks, and blocks evenly into stages.
  function automatic bit params_legal(int w, int blk, int stages);
    return (blk > 0) && (stages > 0) && (w >= blk) &&
           ((w % blk) == 0) && (((w / blk) % stages) == 0);
  endfunction

endpackage

// File: rtl/pipelined_csel_adder_if.sv
// Operand/result handshake bundle between operand-fetch, adder and writeback.
interface pipelined_csel_adder_if
  import adder_pkg::*;
#(
  parameter int W = W_DEFAULT
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  // Producer/consumer side (operand fetch + writeback).
  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  // Adder side.
  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_csel_adder_csel_block.sv
// One carry-select block: both carry-in outcomes are computed in parallel,
// the incoming carry only drives the final 2:1 select.
module csel_block
  import adder_pkg::*;
#(
  parameter int BLK = BLK_DEFAULT
) (
  input  logic [BLK-1:0] a_i,
  input  logic [BLK-1:0] b_i,
  input  logic           cin_i,
  output logic [BLK-1:0] s_o,
  output logic           co_o
);

  logic [BLK:0] s0;
  logic [BLK:0] s1;

  assign s0 = {1'b0, a_i} + {1'b0, b_i};
  assign s1 = {1'b0, a_i} + {1'b0, b_i} + (BLK+1)'(1);

  assign {co_o, s_o} = cin_i ? s1 : s0;

endmodule

// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder/subtractor with valid/ready flow control.
// Register stage r holds the sum bits resolved by stages 0..r, the carry
// into stage r+1, and the still-raw A/B' bits of the stages above it, so
// operands are sampled once and skewed down the pipe.
module pipelined_csel_adder
  import adder_pkg::*;
#(
  parameter int W      = W_DEFAULT,
  parameter int BLK    = BLK_DEFAULT,
  parameter int STAGES = STAGES_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  pipelined_csel_adder_if.slave        bus
);

  localparam int BPS = blocks_per_stage(W, BLK, STAGES);
  localparam int SW  = BPS * BLK;   // result bits resolved per stage

  if (!params_legal(W, BLK, STAGES)) begin : g_param_chk
    $error("pipelined_csel_adder: W must be a multiple of BLK and W/BLK a multiple of STAGES");
  end

  logic [STAGES-1:0] en;    // stage r captures from its upstream this cycle
  logic [STAGES-1:0] vld;

  // Ready ripples back from the consumer: a stage may load when it is empty
  // or when its contents move on in the same cycle.
  always_comb begin
    logic go;
    go = bus.out_ready;
    en = '0;
    for (int r = STAGES - 1; r >= 0; r--) begin
      go    = !vld[r] || go;
      en[r] = go;
    end
  end

  assign bus.in_ready = en[0];

  for (genvar r = 0; r < STAGES; r++) begin : g_stg
    localparam int LO = r * SW;       // result bits already resolved upstream
    localparam int RW = W - LO;       // raw operand bits entering this stage

    logic [RW-1:0]    a_in;
    logic [RW-1:0]    b_in;
    logic             c_in;
    logic             v_in;
    logic [SW-1:0]    bs;
    logic [LO+SW-1:0] s_d;
    logic [LO+SW-1:0] s_q;
    logic             c_d;
    logic             c_q;
    logic             vld_q;

    if (r == 0) begin : g_src
      // Subtraction is A + ~B + 1: invert B here, inject the 1 as carry-in.
      assign a_in = bus.a;
      assign b_in = bus.sub ? ~bus.b : bus.b;
      assign c_in = bus.sub;
      assign v_in = bus.in_valid;
      assign s_d  = bs;
    end else begin : g_src
      assign a_in = g_stg[r-1].g_raw.a_q;
      assign b_in = g_stg[r-1].g_raw.b_q;
      assign c_in = g_stg[r-1].c_q;
      assign v_in = g_stg[r-1].vld_q;
      assign s_d  = {bs, g_stg[r-1].s_q};
    end

    for (genvar j = 0; j < BPS; j++) begin : g_blk
      logic cin;
      logic co;
      if (j == 0) begin : g_c
        assign cin = c_in;
      end else begin : g_c
        assign cin = g_blk[j-1].co;
      end
      csel_block #(.BLK(BLK)) u_blk (
        .a_i   (a_in[j*BLK +: BLK]),
        .b_i   (b_in[j*BLK +: BLK]),
        .cin_i (cin),
        .s_o   (bs[j*BLK +: BLK]),
        .co_o  (co)
      );
    end

    assign c_d     = g_blk[BPS-1].co;
    assign vld[r]  = vld_q;

    // Stage valid, carry and resolved sum advance together under en.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        c_q   <= 1'b0;
        s_q   <= '0;
      end else if (en[r]) begin
        vld_q <= v_in;
        c_q   <= c_d;
        s_q   <= s_d;
      end
    end

    if (r < STAGES - 1) begin : g_raw
      logic [RW-SW-1:0] a_q;
      logic [RW-SW-1:0] b_q;

      // Carry the unresolved upper operand bits to the next stage.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en[r]) begin
          a_q <= a_in[RW-1:SW];
          b_q <= b_in[RW-1:SW];
        end
      end
    end else begin : g_out
      logic ovf_q;

      // Signed overflow: operands agree in sign but the result does not.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (en[r]) begin
          ovf_q <= (a_in[RW-1] == b_in[RW-1]) && (s_d[W-1] != a_in[RW-1]);
        end
      end

      assign bus.out_valid = vld_q;
      assign bus.sum       = s_q;
      assign bus.cout      = c_q;
      assign bus.ovf       = ovf_q;
    end
  end

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Bench for pipelined_csel_adder: directed corners, random streams with
// backpressure, mid-stream reset, and two alternate parameter sets.
module tb_pipelined_csel_adder;
  import adder_pkg::*;

  localparam int S0 = 4;
  localparam int S1 = 1;
  localparam int S2 = 8;

  typedef struct {
    logic [127:0] s;
    logic         co;
    logic         ov;
    int           t;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   acc0  = 0;
  int   out0  = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipelined_csel_adder_if #(.W(128)) bus0 ();
  pipelined_csel_adder_if #(.W(32))  bus1 ();
  pipelined_csel_adder_if #(.W(64))  bus2 ();

  pipelined_csel_adder #(.W(128), .BLK(4), .STAGES(S0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  pipelined_csel_adder #(.W(32),  .BLK(8), .STAGES(S1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  pipelined_csel_adder #(.W(64),  .BLK(2), .STAGES(S2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic at width w.
  function automatic exp_t model(input logic [127:0] a, input logic [127:0] b,
                                 input logic sub, input int w);
    exp_t e;
    logic [129:0] m, am, bm, rm;
    logic signed [129:0] sa, sb, r, lim;
    m  = (130'd1 << w) - 130'd1;
    am = {2'b00, a} & m;
    bm = {2'b00, b} & m;
    sa = am;
    sb = bm;
    if (am[w-1]) sa = sa - (130'sd1 <<< w);
    if (bm[w-1]) sb = sb - (130'sd1 <<< w);
    r   = sub ? sa - sb : sa + sb;
    lim = 130'sd1 <<< (w - 1);
    rm  = r & m;
    e.s  = rm[127:0];
    e.ov = (r >= lim) || (r < -lim);
    e.co = sub ? (am >= bm) : (((am + bm) >> w) != 130'd0);
    e.t  = cyc;
    return e;
  endfunction

  // Scoreboard for the 128-bit instance; also checks held output under stall.
  always @(negedge clk) begin : mon0
    exp_t e;
    if (rst_n) begin
      if (bus0.out_valid && bus0.out_ready) begin
        if (q0.size() == 0) chk("out0 unexpected", 128'(bus0.out_valid), 128'(0));
        else begin
          e = q0.pop_front();
          chk("sum0", bus0.sum, e.s);
          chk("cout0", 128'(bus0.cout), 128'(e.co));
          chk("ovf0", 128'(bus0.ovf), 128'(e.ov));
        end
        out0 <= out0 + 1;
      end else if (bus0.out_valid && q0.size() > 0) begin
        chk("hold0", bus0.sum, q0[0].s);
      end
      if (bus0.in_valid && bus0.in_ready) begin
        q0.push_back(model(bus0.a, bus0.b, bus0.sub, 128));
        acc0 <= acc0 + 1;
      end
    end
  end

  // Scoreboards for the alternate parameter sets (never stalled): exact latency.
  always @(negedge clk) begin : mon1
    exp_t e;
    if (rst_n) begin
      if (bus1.out_valid && bus1.out_ready) begin
        if (q1.size() == 0) chk("out1 unexpected", 128'(bus1.out_valid), 128'(0));
        else begin
          e = q1.pop_front();
          chk("sum1", 128'(bus1.sum), e.s);
          chk("cout1", 128'(bus1.cout), 128'(e.co));
          chk("ovf1", 128'(bus1.ovf), 128'(e.ov));
          chk("lat1", 128'(cyc - e.t), 128'(S1));
        end
      end
      if (bus1.in_valid && bus1.in_ready) q1.push_back(model(128'(bus1.a), 128'(bus1.b), bus1.sub, 32));
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (rst_n) begin
      if (bus2.out_valid && bus2.out_ready) begin
        if (q2.size() == 0) chk("out2 unexpected", 128'(bus2.out_valid), 128'(0));
        else begin
          e = q2.pop_front();
          chk("sum2", 128'(bus2.sum), e.s);
          chk("cout2", 128'(bus2.cout), 128'(e.co));
          chk("ovf2", 128'(bus2.ovf), 128'(e.ov));
          chk("lat2", 128'(cyc - e.t), 128'(S2));
        end
      end
      if (bus2.in_valid && bus2.in_ready) q2.push_back(model(128'(bus2.a), 128'(bus2.b), bus2.sub, 64));
    end
  end

  task automatic rnd_op0();
    bus0.a   = {$urandom, $urandom, $urandom, $urandom};
    bus0.b   = {$urandom, $urandom, $urandom, $urandom};
    bus0.sub = 1'($urandom_range(0, 1));
  endtask

  // Present one operand pair and return just after the edge that takes it.
  task automatic put0(input logic [127:0] a, input logic [127:0] b, input logic sub);
    int n;
    bus0.a = a; bus0.b = b; bus0.sub = sub; bus0.in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus0.in_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("in_ready timeout", 128'(bus0.in_ready), 128'(1));
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
  endtask

  // Single op on an idle pipe; checks latency and values against constants.
  task automatic dir0(input string tag, input logic [127:0] a, input logic [127:0] b,
                      input logic sub, input logic [127:0] es, input logic eco, input logic eov);
    int n;
    bus0.out_ready = 1'b1;
    put0(a, b, sub);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus0.out_valid && n < 20);
    chk({tag, " latency"}, 128'(n), 128'(S0));
    chk({tag, " sum"}, bus0.sum, es);
    chk({tag, " cout"}, 128'(bus0.cout), 128'(eco));
    chk({tag, " ovf"}, 128'(bus0.ovf), 128'(eov));
    @(posedge clk); #1;
  endtask

  task automatic put12(input logic [127:0] a, input logic [127:0] b, input logic sub);
    bus1.a = a[31:0]; bus1.b = b[31:0]; bus1.sub = sub; bus1.in_valid = 1'b1;
    bus2.a = a[63:0]; bus2.b = b[63:0]; bus2.sub = sub; bus2.in_valid = 1'b1;
    @(negedge clk);
    chk("in_ready1", 128'(bus1.in_ready), 128'(1));
    chk("in_ready2", 128'(bus2.in_ready), 128'(1));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] ones;
    logic [127:0] m;
    logic         tk;
    int a0, o0, c0;
    ones = '1;
    bus0.in_valid = 1'b0; bus0.a = '0; bus0.b = '0; bus0.sub = 1'b0; bus0.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.sub = 1'b0; bus1.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.a = '0; bus2.b = '0; bus2.sub = 1'b0; bus2.out_ready = 1'b1;

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst out_valid", 128'(bus0.out_valid), 128'(0));
    chk("rst in_ready", 128'(bus0.in_ready), 128'(1));
    chk("rst sum", bus0.sum, 128'(0));
    chk("rst cout", 128'(bus0.cout), 128'(0));
    chk("rst ovf", 128'(bus0.ovf), 128'(0));
    chk("rst out_valid2", 128'(bus2.out_valid), 128'(0));
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed corners
    dir0("add wrap", ones, 128'd1, 1'b0, 128'd0, 1'b1, 1'b0);
    dir0("sub 5-7", 128'd5, 128'd7, 1'b1, ones - 128'd1, 1'b0, 1'b0);
    dir0("sub ovf", ones >> 1, ones, 1'b1, 128'd1 << 127, 1'b0, 1'b1);

    // Continuous random stream, consumer always ready
    bus0.out_ready = 1'b1;
    c0 = cyc; o0 = out0;
    for (int i = 0; i < 100; i++) begin
      rnd_op0();
      put0(bus0.a, bus0.b, bus0.sub);
    end
    chk("stream cycles", 128'(cyc - c0), 128'(100));
    repeat (S0 + 2) @(posedge clk); #1;
    chk("stream results", 128'(out0 - o0), 128'(100));
    chk("stream drained", 128'(q0.size()), 128'(0));

    // Full backpressure with input pressing
    bus0.out_ready = 1'b0;
    a0 = acc0; o0 = out0;
    rnd_op0(); bus0.in_valid = 1'b1;
    repeat (10) begin
      @(negedge clk); tk = bus0.in_valid && bus0.in_ready;
      @(posedge clk); #1;
      if (tk) rnd_op0();
    end
    @(negedge clk);
    chk("stall accepts", 128'(acc0 - a0), 128'(S0));
    chk("stall in_ready", 128'(bus0.in_ready), 128'(0));
    chk("stall out_valid", 128'(bus0.out_valid), 128'(1));
    @(posedge clk); #1;
    bus0.in_valid = 1'b0; bus0.out_ready = 1'b1;
    repeat (S0 + 4) @(posedge clk); #1;
    chk("stall drain", 128'(out0 - o0), 128'(S0));
    chk("stall drained", 128'(q0.size()), 128'(0));

    // Random valid/ready traffic
    a0 = acc0; o0 = out0;
    repeat (200) begin
      @(negedge clk); tk = bus0.in_valid && bus0.in_ready;
      @(posedge clk); #1;
      bus0.out_ready = ($urandom_range(0, 3) != 0);
      if (!bus0.in_valid || tk) begin
        bus0.in_valid = 1'($urandom_range(0, 1));
        rnd_op0();
      end
    end
    bus0.in_valid = 1'b0; bus0.out_ready = 1'b1;
    repeat (S0 + 4) @(posedge clk); #1;
    chk("random drain", 128'(out0 - o0), 128'(acc0 - a0));
    chk("random drained", 128'(q0.size()), 128'(0));

    // Reset with three results in flight
    bus0.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin rnd_op0(); put0(bus0.a, bus0.b, bus0.sub); end
    @(posedge clk); #1;
    chk("pre-reset out_valid", 128'(bus0.out_valid), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("mid-reset out_valid", 128'(bus0.out_valid), 128'(0));
    chk("mid-reset in_ready", 128'(bus0.in_ready), 128'(1));
    chk("mid-reset sum", bus0.sum, 128'(0));
    q0.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    bus0.out_ready = 1'b1;
    o0 = out0;
    repeat (10) @(posedge clk); #1;
    chk("post-reset results", 128'(out0 - o0), 128'(0));
    dir0("post-reset add", 128'd3, 128'd4, 1'b0, 128'd7, 1'b0, 1'b0);

    // Alternate parameter sets: ripple across every block/stage boundary
    put12(ones, 128'd1, 1'b0);
    put12(128'd0, 128'd0, 1'b1);
    for (int k = 1; k < 16; k++) begin
      m = (128'd1 << (4 * k)) - 128'd1;
      put12(m, 128'd1, 1'b0);
      put12(m + 128'd1, 128'd1, 1'b1);
    end
    for (int i = 0; i < 40; i++)
      put12({$urandom, $urandom, $urandom, $urandom},
            {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)));
    bus1.in_valid = 1'b0; bus2.in_valid = 1'b0;
    repeat (S2 + 4) @(posedge clk); #1;
    chk("sweep1 drained", 128'(q1.size()), 128'(0));
    chk("sweep2 drained", 128'(q2.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
